serializer_param: RTL
=====================

// Module: serializer_param
// PURPOSE
//   Parametrised parallel-to-serial shifter with a valid/ready load handshake.
//   Supersedes the fixed 16-bit free-running serializer.
//   Adds: configurable word width and bit order, framing strobes, idle line level,
//   and gapless back-to-back word streaming.
//   Sits between a parallel word producer (FSM/FIFO) and a 1-bit line driver.
// PARAMETERS
//   WIDTH       16  bits per word; legal range >= 2
//   LSB_FIRST   0   0: data_in[WIDTH-1] shifted out first; 1: data_in[0] first
//   IDLE_LEVEL  0   value driven on sout while no word is being sent
// PORTS
//   clk          in   1      rising-edge clock, the only clock domain
//   rst_n        in   1      reset, synchronous, active-low
//   data_in      in   WIDTH  parallel word; sampled only on accept
//   load_valid   in   1      producer has a word on data_in
//   load_ready   out  1      block can take a word this cycle (combinational)
//   sout         out  1      serial data, registered
//   sout_valid   out  1      sout carries a data bit this cycle
//   frame_start  out  1      high with the first bit of each word
//   frame_end    out  1      high with the last bit of each word
//   busy         out  1      equals sout_valid; provided for status
// BEHAVIOUR
//   Reset (rst_n low at a rising clk edge):
//     - state=IDLE, bit_cnt=0, shift register cleared.
//     - sout=IDLE_LEVEL; sout_valid, frame_start, frame_end, busy = 0.
//     - Reset takes effect at the next edge even mid-word; the partial word is dropped.
//   Counter: bit_cnt is $clog2(WIDTH) bits and counts 0..WIDTH-1 within a word.
//   States: IDLE, SHIFT.
//   load_ready = (state==IDLE) || (state==SHIFT && bit_cnt==WIDTH-1).
//   Accept = load_valid && load_ready at a rising edge. On that edge:
//     - capture data_in into the shift register;
//     - sout <= first bit per LSB_FIRST;
//     - bit_cnt <= 0; sout_valid <= 1; frame_start <= 1; state <= SHIFT.
//     - Latency: first bit is visible in the cycle after the accept edge.
//   SHIFT, bit_cnt < WIDTH-1: each edge outputs the next bit, bit_cnt++,
//     frame_start <= 0. frame_end <= 1 on the edge that sets bit_cnt to WIDTH-1.
//   SHIFT, bit_cnt == WIDTH-1 (last bit on the line):
//     - With accept: the next word starts on the next edge. No idle gap and no
//       repeated bit; frame_end falls and frame_start rises on the same edge.
//     - Without accept: state <= IDLE, sout <= IDLE_LEVEL, sout_valid <= 0,
//       frame_end <= 0.
//   load_valid while load_ready is low is ignored. The producer must hold the
//     word until it is accepted.
//   data_in changes mid-word have no effect on the word being sent.
//   A word occupies exactly WIDTH cycles of sout_valid.
//   Sustained throughput is 1 word per WIDTH cycles.
//   No X on any output after reset; outputs are registered except load_ready.
// TESTING
//   1 Reset: hold rst_n=0 for 3 clocks with load_valid=1 -> sout=IDLE_LEVEL;
//     valid, strobes and busy are 0; nothing is accepted.
//   2 Single word, defaults: data_in=16'hA5C3, load_valid pulsed 1 cycle
//     -> sout = 1010_0101_1100_0011 over 16 cycles; frame_start on bit 1,
//     frame_end on bit 16; then idle with load_ready=1.
//   3 Back-to-back: 16'hFFFF then 16'h0001 offered continuously
//     -> 32 contiguous sout_valid cycles; load_ready high only on bit 16;
//     frame_end and frame_start on adjacent cycles.
//   4 Bit order: WIDTH=8, LSB_FIRST=1, IDLE_LEVEL=1, word 8'h01
//     -> bits 1,0,0,0,0,0,0,0; sout returns to 1 after the word.
//   5 Busy: change data_in and pulse load_valid during bits 2..15
//     -> no accept; the original word is transmitted unchanged.
//   6 Reset mid-word: rst_n=0 at bit 7 -> the next cycle shows reset values;
//     after release, a new word starts cleanly with frame_start.

Source files
------------

// File: rtl/serializer_param_if.sv
// Load handshake and serial line bundle for serializer_param.
// The master side is the word producer / line consumer, the slave side is the serializer.
interface serializer_param_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output data_in, load_valid,
    input  load_ready, sout, sout_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, sout, sout_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/serializer_param.sv
// Parametrised parallel-to-serial shifter with valid/ready load and framing strobes.
// A new word can be accepted while the last bit of the current one is on the line.
module serializer_param #(
  parameter int       WIDTH      = 16,
  parameter bit       LSB_FIRST  = 1'b0,
  parameter bit       IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  serializer_param_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q,      state_d;
  logic [CW-1:0]    bitCnt_q,     bitCnt_d;
  logic [WIDTH-1:0] shift_q,      shift_d;
  logic             sout_q,       sout_d;
  logic             soutValid_q,  soutValid_d;
  logic             frameStart_q, frameStart_d;
  logic             frameEnd_q,   frameEnd_d;

  logic loadReady;
  logic accept;

  assign loadReady = (state_q == ST_IDLE) ||
                     ((state_q == ST_SHIFT) && (bitCnt_q == LAST_BIT));
  assign accept    = bus.load_valid && loadReady;

  // The register holds the bits still to send; the one on the line has already left it.
  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    sout_d       = sout_q;
    soutValid_d  = soutValid_q;
    frameStart_d = frameStart_q;
    frameEnd_d   = frameEnd_q;

    if (accept) begin
      if (LSB_FIRST) begin
        sout_d  = bus.data_in[0];
        shift_d = {1'b0, bus.data_in[WIDTH-1:1]};
      end else begin
        sout_d  = bus.data_in[WIDTH-1];
        shift_d = {bus.data_in[WIDTH-2:0], 1'b0};
      end
      bitCnt_d     = '0;
      soutValid_d  = 1'b1;
      frameStart_d = 1'b1;
      frameEnd_d   = 1'b0;
      state_d      = ST_SHIFT;
    end else if (state_q == ST_SHIFT) begin
      if (bitCnt_q != LAST_BIT) begin
        if (LSB_FIRST) begin
          sout_d  = shift_q[0];
          shift_d = {1'b0, shift_q[WIDTH-1:1]};
        end else begin
          sout_d  = shift_q[WIDTH-1];
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
        bitCnt_d     = bitCnt_q + CW'(1);
        frameStart_d = 1'b0;
        frameEnd_d   = (bitCnt_d == LAST_BIT);
      end else begin
        state_d      = ST_IDLE;
        sout_d       = IDLE_LEVEL;
        soutValid_d  = 1'b0;
        frameStart_d = 1'b0;
        frameEnd_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      sout_q       <= IDLE_LEVEL;
      soutValid_q  <= 1'b0;
      frameStart_q <= 1'b0;
      frameEnd_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      sout_q       <= sout_d;
      soutValid_q  <= soutValid_d;
      frameStart_q <= frameStart_d;
      frameEnd_q   <= frameEnd_d;
    end
  end

  assign bus.load_ready  = loadReady;
  assign bus.sout        = sout_q;
  assign bus.sout_valid  = soutValid_q;
  assign bus.frame_start = frameStart_q;
  assign bus.frame_end   = frameEnd_q;
  assign bus.busy        = soutValid_q;

endmodule
